// File: rtl/rv32_io_responder.sv
// Memory-mapped IO target for the rv32 MEM stage: LEDs, switches, cycle counter,
// countdown timer with interrupt, and a byte FIFO feeding an 8N1 UART transmitter.
module rv32_io_responder #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] io_addr,
    input  logic        io_we,
    input  logic [3:0]  io_be,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [9:0]  sw_in,
    output logic [9:0]  ledr_out,
    output logic        uart_tx,
    output logic        timer_irq
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL   = CNT_W'(FIFO_DEPTH);

    localparam logic [5:0] OFF_LED    = 6'd0;
    localparam logic [5:0] OFF_SW     = 6'd1;
    localparam logic [5:0] OFF_CYCLE  = 6'd2;
    localparam logic [5:0] OFF_TIMER  = 6'd3;
    localparam logic [5:0] OFF_STATUS = 6'd4;
    localparam logic [5:0] OFF_TXDATA = 6'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [9:0]        led_q, led_d;
    logic [9:0]        sw_meta_q, sw_sync_q;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       timer_q, timer_d;
    logic              exp_q, exp_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];
    logic [7:0]        fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic [5:0]  off_s;
    logic        we_led_s, we_timer_s, we_status_s, we_tx_s;
    logic        fifo_full_s, fifo_empty_s, push_req_s, push_ok_s, push_drop_s, pop_s;
    logic        expire_s, busy_s;
    logic [31:0] status_s;
    logic        unused_addr_s;

    assign off_s        = io_addr[7:2];
    assign unused_addr_s = ^io_addr[31:8];
    assign we_led_s     = io_we && (off_s == OFF_LED);
    assign we_timer_s   = io_we && (off_s == OFF_TIMER);
    assign we_status_s  = io_we && (off_s == OFF_STATUS);
    assign we_tx_s      = io_we && (off_s == OFF_TXDATA);
    assign fifo_full_s  = (count_q == FIFO_FULL);
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign push_req_s   = we_tx_s && io_be[0];
    assign push_ok_s    = push_req_s && !fifo_full_s;
    assign push_drop_s  = push_req_s && fifo_full_s;
    assign busy_s       = (state_q != ST_IDLE);
    assign status_s     = {27'd0, busy_s, ovf_q, fifo_empty_s, fifo_full_s, exp_q};

    // Register file next-state: LEDs, cycle counter, timer and sticky status flags.
    always_comb begin
        led_d = {(we_led_s && io_be[1]) ? io_wdata[9:8] : led_q[9:8],
                 (we_led_s && io_be[0]) ? io_wdata[7:0] : led_q[7:0]};
        cycle_d  = cycle_q + 32'd1;
        timer_d  = timer_q;
        expire_s = 1'b0;
        // A write always overrides the decrement; only a 1->0 step counts as expiry.
        if (we_timer_s) begin
            timer_d = merge_bytes(timer_q, io_wdata, io_be);
        end else if (timer_q != 32'd0) begin
            timer_d  = timer_q - 32'd1;
            expire_s = (timer_q == 32'd1);
        end else begin
            timer_d = timer_q;
        end
        exp_d = expire_s    | (exp_q & ~(we_status_s & io_be[0] & io_wdata[0]));
        ovf_d = push_drop_s | (ovf_q & ~(we_status_s & io_be[0] & io_wdata[3]));
    end

    // TX FIFO pointers, occupancy and storage.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (push_ok_s) begin
            fifo_mem_d[wr_ptr_q] = io_wdata[7:0];
        end else begin
            fifo_mem_d = fifo_mem_q;
        end
        wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // UART transmit FSM; uart_tx is registered from the next-state bit value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    state_d = ST_START;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (baud_q == {BAUD_W{1'b0}}) begin
                    state_d = ST_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == {BAUD_W{1'b0}}) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                // Chain straight into the next START so frames run back-to-back.
                if (baud_q == {BAUD_W{1'b0}}) begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        state_d = ST_START;
                        baud_d  = BAUD_RELOAD;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Read mux; sampled into io_rdata so data appears one cycle after the address.
    always_comb begin
        case (off_s)
            OFF_LED:    rdata_d = {22'd0, led_q};
            OFF_SW:     rdata_d = {22'd0, sw_sync_q};
            OFF_CYCLE:  rdata_d = cycle_q;
            OFF_TIMER:  rdata_d = timer_q;
            OFF_STATUS: rdata_d = status_s;
            default:    rdata_d = 32'd0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q      <= 10'd0;
            sw_meta_q  <= 10'd0;
            sw_sync_q  <= 10'd0;
            cycle_q    <= 32'd0;
            timer_q    <= 32'd0;
            exp_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rdata_q    <= 32'd0;
            fifo_mem_q <= '{default: 8'd0};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            state_q    <= ST_IDLE;
            baud_q     <= {BAUD_W{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            led_q      <= led_d;
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
            cycle_q    <= cycle_d;
            timer_q    <= timer_d;
            exp_q      <= exp_d;
            ovf_q      <= ovf_d;
            rdata_q    <= rdata_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign io_rdata  = rdata_q;
    assign ledr_out  = led_q;
    assign uart_tx   = tx_q;
    assign timer_irq = exp_q;

endmodule
